rep_window_checker: RTL and testbench

- Synthesizable RTL monitor that consumes the window/event/qualifier trio (win_i, evt_i, qual_i).
- Mirrors in hardware the repetition checks normally written as assertions: counts evt_i occurrences inside a window opened by a rising win_i, then requires a qualifier after the Nth occurrence.
- Reports pass/fail as single-cycle pulses with a fail code.
- Sits downstream of the stimulus/DUT signals; feeds a status/interrupt collector.

---
 rtl/rep_chk_pkg.sv | 27 ++
 rtl/rep_chk_timer.sv | 31 +++
 rtl/rep_window_checker.sv | 179 +++++++++++++++++
 tb/tb_rep_window_checker.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_chk_pkg.sv
// Shared types and default widths for the repetition-window checker.
// Contents: default counter/timer widths, FSM state, fail code and mode encodings.
package rep_chk_pkg;

   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned TMR_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_QUAL  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FL_NONE    = 2'd0,
      FL_UNDER   = 2'd1,
      FL_OVER    = 2'd2,
      FL_TIMEOUT = 2'd3
   } fail_e;

   typedef enum logic {
      MD_REP  = 1'b0,
      MD_GOTO = 1'b1
   } mode_e;

endpackage

// File: rtl/rep_chk_timer.sv
// Loadable down-counter that stops at zero; done_c flags a zero count.
// Ports: clk, rst_n, load (takes load_val), en (decrement), load_val, done_c.
module rep_chk_timer
   import rep_chk_pkg::*;
#(
   parameter int unsigned TMR_W = TMR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [TMR_W-1:0] load_val,
   output logic             done_c
);

   logic [TMR_W-1:0] count;

   // Load has priority; decrement saturates at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - TMR_W'(1);
      end
   end

   assign done_c = (count == '0);

endmodule

// File: rtl/rep_window_checker.sv
// Hardware repetition monitor: a rising win_i opens a check that counts evt_i
// up to a target N, then waits for qual_i no earlier than a programmed delay.
// Ports: clk, rst_n; cfg_mode/cfg_target/cfg_qual_dly/cfg_timeout (latched at
// start); win_i, evt_i, qual_i, clr_i; busy_o, cnt_o, pass_o, fail_o, fail_code_o.
module rep_window_checker
   import rep_chk_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned TMR_W = TMR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_mode,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [TMR_W-1:0] cfg_qual_dly,
   input  logic [TMR_W-1:0] cfg_timeout,
   input  logic             win_i,
   input  logic             evt_i,
   input  logic             qual_i,
   input  logic             clr_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic [1:0]       fail_code_o
);

   localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
   localparam logic [1:0] S_COUNT = 2'(ST_COUNT);
   localparam logic [1:0] S_QUAL  = 2'(ST_QUAL);
   localparam logic [1:0] S_DONE  = 2'(ST_DONE);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state, nxt_state, code_nxt;
   logic             win_q, mode_q, tmo_en_q;
   logic [CNT_W-1:0] tgt_q, tgt_in, cnt_nxt, cnt_inc;
   logic [TMR_W-1:0] dly_q, dly_in, tmo_in, dly_ld_val;
   logic             set_pass, set_fail, cfg_latch, dly_load, tmo_load, reached;
   logic             win_fall, dly_done, tmo_done, tmo_hit;

   // Effective config: zero target/delay mean one. The delay timer is loaded one
   // short so it hits zero exactly dly cycles after the Nth event; the timeout
   // timer is loaded two short because the start cycle itself counts.
   assign tgt_in     = (cfg_target == '0) ? CNT_W'(1) : cfg_target;
   assign dly_in     = (cfg_qual_dly == '0) ? '0 : cfg_qual_dly - TMR_W'(1);
   assign tmo_in     = (cfg_timeout < TMR_W'(2)) ? '0 : cfg_timeout - TMR_W'(2);
   assign dly_ld_val = (state == S_IDLE) ? dly_in : dly_q;
   assign cnt_inc    = (cnt_o == CNT_MAX) ? cnt_o : cnt_o + CNT_W'(1);
   assign win_fall   = win_q & ~win_i;
   assign tmo_hit    = tmo_en_q & tmo_done;

   rep_chk_timer #(.TMR_W(TMR_W)) u_dly_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dly_load),
      .en       (state == S_QUAL),
      .load_val (dly_ld_val),
      .done_c   (dly_done)
   );

   rep_chk_timer #(.TMR_W(TMR_W)) u_tmo_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmo_load),
      .en       ((state == S_COUNT) || (state == S_QUAL)),
      .load_val (tmo_in),
      .done_c   (tmo_done)
   );

   // Next-state and decision logic; priority clr > pass > OVER > UNDER > TIMEOUT
   always_comb begin
      nxt_state = state;
      cnt_nxt   = cnt_o;
      code_nxt  = fail_code_o;
      set_pass  = 1'b0;
      set_fail  = 1'b0;
      cfg_latch = 1'b0;
      dly_load  = 1'b0;
      tmo_load  = 1'b0;
      reached   = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_i && !win_q) begin
               cfg_latch = 1'b1;
               tmo_load  = 1'b1;
               code_nxt  = 2'(FL_NONE);
               cnt_nxt   = evt_i ? CNT_W'(1) : '0;
               if (cfg_timeout == TMR_W'(1)) begin
                  nxt_state = S_DONE;
                  set_fail  = 1'b1;
                  code_nxt  = 2'(FL_TIMEOUT);
               end else if (evt_i && (tgt_in == CNT_W'(1))) begin
                  nxt_state = S_QUAL;
                  dly_load  = 1'b1;
               end else begin
                  nxt_state = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            if (evt_i) cnt_nxt = cnt_inc;
            reached = (cnt_nxt == tgt_q);
            // A window falling on the Nth event still counts as reached
            if (!reached && win_fall) begin
               nxt_state = S_DONE;
               set_fail  = 1'b1;
               code_nxt  = 2'(FL_UNDER);
            end else if (tmo_hit) begin
               nxt_state = S_DONE;
               set_fail  = 1'b1;
               code_nxt  = 2'(FL_TIMEOUT);
            end else if (reached) begin
               nxt_state = S_QUAL;
               dly_load  = 1'b1;
            end
         end
         S_QUAL: begin
            if (qual_i && dly_done) begin
               nxt_state = S_DONE;
               set_pass  = 1'b1;
            end else if ((mode_q == 1'(MD_REP)) && evt_i) begin
               nxt_state = S_DONE;
               set_fail  = 1'b1;
               code_nxt  = 2'(FL_OVER);
            end else if (tmo_hit) begin
               nxt_state = S_DONE;
               set_fail  = 1'b1;
               code_nxt  = 2'(FL_TIMEOUT);
            end
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase
      if (clr_i) begin
         nxt_state = S_IDLE;
         cnt_nxt   = cnt_o;
         code_nxt  = 2'(FL_NONE);
         set_pass  = 1'b0;
         set_fail  = 1'b0;
         cfg_latch = 1'b0;
         dly_load  = 1'b0;
         tmo_load  = 1'b0;
      end
   end

   // State, latched config and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         win_q       <= 1'b1;
         cnt_o       <= '0;
         busy_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         fail_code_o <= '0;
         mode_q      <= 1'b0;
         tgt_q       <= '0;
         dly_q       <= '0;
         tmo_en_q    <= 1'b0;
      end else begin
         state       <= nxt_state;
         win_q       <= win_i;
         cnt_o       <= cnt_nxt;
         busy_o      <= (nxt_state != S_IDLE);
         pass_o      <= set_pass;
         fail_o      <= set_fail;
         fail_code_o <= code_nxt;
         if (cfg_latch) begin
            mode_q   <= cfg_mode;
            tgt_q    <= tgt_in;
            dly_q    <= dly_in;
            tmo_en_q <= (cfg_timeout != '0);
         end
      end
   end

endmodule

// File: tb/tb_rep_window_checker.sv
// Self-checking bench for rep_window_checker: directed scenarios with fixed
// expected cycles plus a randomized run against a phase/elapsed-time model.
module tb_rep_window_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_mode;
   logic [7:0]  cfg_target;
   logic [15:0] cfg_qual_dly;
   logic [15:0] cfg_timeout;
   logic        win_i, evt_i, qual_i, clr_i;
   logic        busy_o, pass_o, fail_o;
   logic [7:0]  cnt_o;
   logic [1:0]  fail_code_o;

   int total, bad, cyc;

   rep_window_checker #(.CNT_W(8), .TMR_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_mode    (cfg_mode),
      .cfg_target  (cfg_target),
      .cfg_qual_dly(cfg_qual_dly),
      .cfg_timeout (cfg_timeout),
      .win_i       (win_i),
      .evt_i       (evt_i),
      .qual_i      (qual_i),
      .clr_i       (clr_i),
      .busy_o      (busy_o),
      .cnt_o       (cnt_o),
      .pass_o      (pass_o),
      .fail_o      (fail_o),
      .fail_code_o (fail_code_o)
   );

   always #5 clk = ~clk;

   // Reference model: check phases with elapsed-cycle arithmetic
   localparam int M_IDLE = 0, M_COUNT = 1, M_QUAL = 2, M_DONE = 3;
   int m_st, m_cnt, m_code, m_start, m_nth, m_tgt, m_dly, m_tmo;
   bit m_mode, m_prev_win, e_busy, e_pass, e_fail;

   function automatic bit m_timed_out();
      return (m_tmo != 0) && ((cyc - m_start) >= (m_tmo - 1));
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_cnt = 0; m_code = 0; m_prev_win = 1'b1;
      m_tmo = 0; m_start = 0; m_nth = 0; m_tgt = 1; m_dly = 1; m_mode = 1'b0;
      e_busy = 1'b0; e_pass = 1'b0; e_fail = 1'b0;
   endtask

   task automatic model_step();
      bit fall;
      fall   = m_prev_win && !win_i;
      e_pass = 1'b0;
      e_fail = 1'b0;
      if (clr_i) begin
         m_st = M_IDLE; m_code = 0;
      end else begin
         case (m_st)
            M_IDLE: if (win_i && !m_prev_win) begin
               m_mode  = cfg_mode;
               m_tgt   = (cfg_target == 0) ? 1 : int'(cfg_target);
               m_dly   = (cfg_qual_dly == 0) ? 1 : int'(cfg_qual_dly);
               m_tmo   = int'(cfg_timeout);
               m_start = cyc;
               m_code  = 0;
               m_cnt   = evt_i ? 1 : 0;
               if (m_timed_out()) begin
                  m_st = M_DONE; e_fail = 1'b1; m_code = 3;
               end else if (m_cnt >= m_tgt) begin
                  m_st = M_QUAL; m_nth = cyc;
               end else begin
                  m_st = M_COUNT;
               end
            end
            M_COUNT: begin
               if (evt_i && m_cnt < 255) m_cnt++;
               if (m_cnt < m_tgt && fall) begin
                  m_st = M_DONE; e_fail = 1'b1; m_code = 1;
               end else if (m_timed_out()) begin
                  m_st = M_DONE; e_fail = 1'b1; m_code = 3;
               end else if (m_cnt == m_tgt) begin
                  m_st = M_QUAL; m_nth = cyc;
               end
            end
            M_QUAL: begin
               if (qual_i && (cyc - m_nth) >= m_dly) begin
                  m_st = M_DONE; e_pass = 1'b1;
               end else if (!m_mode && evt_i) begin
                  m_st = M_DONE; e_fail = 1'b1; m_code = 2;
               end else if (m_timed_out()) begin
                  m_st = M_DONE; e_fail = 1'b1; m_code = 3;
               end
            end
            default: m_st = M_IDLE;
         endcase
      end
      m_prev_win = win_i;
      e_busy = (m_st != M_IDLE);
   endtask

   task automatic step_cycle();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic quiet(input int n);
      win_i = 1'b0; evt_i = 1'b0; qual_i = 1'b0; clr_i = 1'b0;
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   // Drives one scenario; cycle k inputs, outputs observed belong to cycle k+1
   task automatic run_seq(input bit mode, input int tgt, input int dly, input int tmo,
                          input int rise, input int fall, input logic [31:0] evt_m,
                          input logic [31:0] qual_m, input logic [31:0] clr_m, input int ncyc,
                          output int pass_at, output int fail_at, output int code_at,
                          output int cnt_at, output int busy_n);
      pass_at = -1; fail_at = -1; code_at = -1; cnt_at = -1; busy_n = 0;
      cfg_mode = mode; cfg_target = 8'(tgt); cfg_qual_dly = 16'(dly); cfg_timeout = 16'(tmo);
      for (int k = 0; k < ncyc; k++) begin
         if (k >= 2) begin
            cfg_mode     = 1'($urandom_range(0, 1));
            cfg_target   = 8'($urandom_range(0, 255));
            cfg_qual_dly = 16'($urandom_range(0, 9));
            cfg_timeout  = 16'($urandom_range(0, 3));
         end
         win_i  = (k >= rise) && (k < fall);
         evt_i  = evt_m[k];
         qual_i = qual_m[k];
         clr_i  = clr_m[k];
         step_cycle();
         if (busy_o) busy_n++;
         if (pass_o && pass_at < 0) begin
            pass_at = k + 1; cnt_at = int'(cnt_o); code_at = int'(fail_code_o);
         end
         if (fail_o && fail_at < 0) begin
            fail_at = k + 1; cnt_at = int'(cnt_o); code_at = int'(fail_code_o);
         end
      end
      quiet(3);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy_o, pass_o, fail_o, fail_code_o, cnt_o} !== 13'd0) begin
         bad++;
         $display("FAIL reset outputs got=%b want=0", {busy_o, pass_o, fail_o, fail_code_o, cnt_o});
      end
      rst_n = 1'b1;
      model_reset();
      quiet(2);
   endtask

   task automatic test_rep_pass();
      int p, f, c, n, b;
      run_seq(1'b0, 5, 1, 0, 1, 12, 32'h554, 32'h1_0000, 32'h0, 22, p, f, c, n, b);
      total++; if (p !== 17) begin bad++; $display("FAIL rep_pass pass_cycle got=%0d want=17", p); end
      total++; if (f !== -1) begin bad++; $display("FAIL rep_pass fail_cycle got=%0d want=-1", f); end
      total++; if (n !== 5) begin bad++; $display("FAIL rep_pass cnt got=%0d want=5", n); end
      total++; if (c !== 0) begin bad++; $display("FAIL rep_pass code got=%0d want=0", c); end
      total++; if (b !== 16) begin bad++; $display("FAIL rep_pass busy_cycles got=%0d want=16", b); end
   endtask

   task automatic test_rep_over();
      int p, f, c, n, b;
      run_seq(1'b0, 5, 1, 0, 1, 12, 32'h2554, 32'h1_0000, 32'h0, 20, p, f, c, n, b);
      total++; if (f !== 14) begin bad++; $display("FAIL rep_over fail_cycle got=%0d want=14", f); end
      total++; if (c !== 2) begin bad++; $display("FAIL rep_over code got=%0d want=2", c); end
      total++; if (p !== -1) begin bad++; $display("FAIL rep_over pass_cycle got=%0d want=-1", p); end
   endtask

   task automatic test_under();
      int p, f, c, n, b;
      run_seq(1'b0, 5, 1, 0, 1, 10, 32'h154, 32'h0, 32'h0, 16, p, f, c, n, b);
      total++; if (f !== 11) begin bad++; $display("FAIL under fail_cycle got=%0d want=11", f); end
      total++; if (c !== 1) begin bad++; $display("FAIL under code got=%0d want=1", c); end
      total++; if (n !== 4) begin bad++; $display("FAIL under cnt got=%0d want=4", n); end
   endtask

   task automatic test_goto();
      int p, f, c, n, b;
      run_seq(1'b1, 5, 5, 0, 1, 20, 32'h1554, 32'hA000, 32'h0, 24, p, f, c, n, b);
      total++; if (p !== 16) begin bad++; $display("FAIL goto pass_cycle got=%0d want=16", p); end
      total++; if (f !== -1) begin bad++; $display("FAIL goto fail_cycle got=%0d want=-1", f); end
      total++; if (n !== 5) begin bad++; $display("FAIL goto cnt got=%0d want=5", n); end
   endtask

   task automatic test_timeout();
      int p, f, c, n, b;
      run_seq(1'b0, 5, 1, 8, 1, 25, 32'h54, 32'h0, 32'h0, 28, p, f, c, n, b);
      total++; if (f !== 9) begin bad++; $display("FAIL timeout fail_cycle got=%0d want=9", f); end
      total++; if (c !== 3) begin bad++; $display("FAIL timeout code got=%0d want=3", c); end
      total++; if (n !== 3) begin bad++; $display("FAIL timeout cnt got=%0d want=3", n); end
      total++; if (fail_code_o !== 2'd3) begin
         bad++; $display("FAIL timeout code_held got=%0d want=3", fail_code_o);
      end
   endtask

   task automatic test_clr();
      int p, f, c, n, b;
      run_seq(1'b0, 2, 3, 0, 1, 20, 32'hC, 32'h80, 32'h20, 24, p, f, c, n, b);
      total++; if (p !== -1 || f !== -1) begin
         bad++; $display("FAIL clr pulses got pass=%0d fail=%0d want=-1/-1", p, f);
      end
      total++; if (b !== 4) begin bad++; $display("FAIL clr busy_cycles got=%0d want=4", b); end
      total++; if (fail_code_o !== 2'd0) begin
         bad++; $display("FAIL clr code got=%0d want=0", fail_code_o);
      end
   endtask

   task automatic test_priority();
      int p, f, c, n, b;
      run_seq(1'b0, 2, 1, 0, 1, 12, 32'h2C, 32'h20, 32'h0, 14, p, f, c, n, b);
      total++; if (p !== 6 || f !== -1) begin
         bad++; $display("FAIL prio_qual_evt got pass=%0d fail=%0d want=6/-1", p, f);
      end
      run_seq(1'b0, 3, 1, 0, 1, 4, 32'h1C, 32'h40, 32'h0, 10, p, f, c, n, b);
      total++; if (p !== 7 || f !== -1) begin
         bad++; $display("FAIL prio_fall_nth got pass=%0d fail=%0d want=7/-1", p, f);
      end
   endtask

   task automatic test_reset_mid();
      int busy_n;
      cfg_mode = 1'b0; cfg_target = 8'd5; cfg_qual_dly = 16'd1; cfg_timeout = 16'd0;
      win_i = 1'b1; evt_i = 1'b1;
      step_cycle();
      step_cycle();
      total++; if (busy_o !== 1'b1 || cnt_o !== 8'd2) begin
         bad++; $display("FAIL rst_mid pre got busy=%b cnt=%0d want=1/2", busy_o, cnt_o);
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({busy_o, pass_o, fail_o, fail_code_o, cnt_o} !== 13'd0) begin
         bad++; $display("FAIL rst_mid async got=%b want=0", {busy_o, pass_o, fail_o, fail_code_o, cnt_o});
      end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      busy_n = 0;
      for (int i = 0; i < 4; i++) begin
         step_cycle();
         if (busy_o) busy_n++;
      end
      total++; if (busy_n !== 0) begin
         bad++; $display("FAIL win_high_release busy_cycles got=%0d want=0", busy_n);
      end
      quiet(3);
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 7) == 0) win_i = ~win_i;
         evt_i        = ($urandom_range(0, 9) < 4);
         qual_i       = ($urandom_range(0, 3) == 0);
         clr_i        = ($urandom_range(0, 59) == 0);
         cfg_mode     = 1'($urandom_range(0, 1));
         cfg_target   = 8'($urandom_range(0, 4));
         cfg_qual_dly = 16'($urandom_range(0, 4));
         cfg_timeout  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 14)) : 16'd0;
         step_cycle();
         total++;
         if ({busy_o, pass_o, fail_o, fail_code_o, cnt_o} !==
             {e_busy, e_pass, e_fail, 2'(m_code), 8'(m_cnt)}) begin
            bad++;
            $display("FAIL random cyc=%0d got busy/pass/fail/code/cnt=%b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     cyc, busy_o, pass_o, fail_o, fail_code_o, cnt_o,
                     e_busy, e_pass, e_fail, m_code, m_cnt);
         end
      end
      quiet(4);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      rst_n = 1'b0;
      cfg_mode = 1'b0; cfg_target = 8'd0; cfg_qual_dly = 16'd0; cfg_timeout = 16'd0;
      win_i = 1'b0; evt_i = 1'b0; qual_i = 1'b0; clr_i = 1'b0;
      model_reset();
      test_reset();
      test_rep_pass();
      test_rep_over();
      test_under();
      test_goto();
      test_timeout();
      test_clr();
      test_priority();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
